// File: rtl/udt_pkg.sv
// rtl/udt_pkg.sv - shared UDT header constants, routing types and first-beat classifier
package udt_pkg;

    typedef enum logic [14:0] {
        UDT_CTRL_HANDSHAKE  = 15'd0,
        UDT_CTRL_KEEPALIVE  = 15'd1,
        UDT_CTRL_ACK        = 15'd2,
        UDT_CTRL_NAK        = 15'd3,
        UDT_CTRL_CONGESTION = 15'd4,
        UDT_CTRL_SHUTDOWN   = 15'd5,
        UDT_CTRL_ACK2       = 15'd6,
        UDT_CTRL_DROPREQ    = 15'd7,
        UDT_CTRL_USER       = 15'h7FFF
    } udt_ctrl_e;

    localparam int UDT_FLAG_BIT = 63;
    localparam int UDT_TYPE_HI  = 62;
    localparam int UDT_TYPE_LO  = 48;

    typedef enum logic [1:0] {
        DEST_HS   = 2'd0,
        DEST_CTL  = 2'd1,
        DEST_DAT  = 2'd2,
        DEST_DROP = 2'd3
    } dest_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FWD     = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    // A first beat that is also the last cannot carry a full 16-byte header.
    function automatic dest_e udt_classify(
        input logic [63:0] hdr,
        input logic        last,
        input logic        conn,
        input logic [14:0] max_ctrl
    );
        logic [14:0] ctype;
        ctype = hdr[UDT_TYPE_HI:UDT_TYPE_LO];
        if (last)
            return DEST_DROP;
        if (!hdr[UDT_FLAG_BIT])
            return conn ? DEST_DAT : DEST_DROP;
        if (ctype == UDT_CTRL_HANDSHAKE)
            return DEST_HS;
        if (ctype <= max_ctrl || ctype == UDT_CTRL_USER)
            return DEST_CTL;
        return DEST_DROP;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - single-entry stream register slice, one cycle latency
module axis_reg_slice #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    // Refill in the same cycle the held beat drains, so streaming is full rate.
    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tvalid <= 1'b1;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/udt_rx_demux.sv
// rtl/udt_rx_demux.sv - classifies ingress UDT packets and steers them to handshake, control or data streams
module udt_rx_demux
    import udt_pkg::*;
#(
    parameter int MAX_CTRL_TYPE = 7,
    parameter int DROP_CNT_W    = 16
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic [63:0]           s_tdata,
    input  logic [7:0]            s_tkeep,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  conn_up,
    output logic [63:0]           hs_tdata,
    output logic [7:0]            hs_tkeep,
    output logic                  hs_tvalid,
    output logic                  hs_tlast,
    input  logic                  hs_tready,
    output logic [63:0]           ctl_tdata,
    output logic [7:0]            ctl_tkeep,
    output logic                  ctl_tvalid,
    output logic                  ctl_tlast,
    input  logic                  ctl_tready,
    output logic [63:0]           dat_tdata,
    output logic [7:0]            dat_tkeep,
    output logic                  dat_tvalid,
    output logic                  dat_tlast,
    input  logic                  dat_tready,
    output logic                  rsp_pulse,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [14:0] MAX_TYPE = 15'(MAX_CTRL_TYPE);

    state_e     state_q, state_d;
    dest_e      dest_q, dest_d;
    dest_e      first_dest;
    dest_e      sel;
    logic [2:0] slice_ready;
    logic [2:0] slice_load;
    logic       route_ready;
    logic       accept;
    logic       first_beat;

    assign first_dest = udt_classify(s_tdata, s_tlast, conn_up, MAX_TYPE);
    assign first_beat = (state_q == ST_IDLE);

    // In IDLE the route follows the live header so a packet to an idle port
    // is never held back by a stalled port used by the previous packet.
    always_comb begin
        sel = dest_q;
        case (state_q)
            ST_IDLE: sel = first_dest;
            ST_FWD:  sel = dest_q;
            default: sel = DEST_DROP;
        endcase
    end

    always_comb begin
        route_ready = 1'b1;
        case (sel)
            DEST_HS:  route_ready = slice_ready[0];
            DEST_CTL: route_ready = slice_ready[1];
            DEST_DAT: route_ready = slice_ready[2];
            default:  route_ready = 1'b1;
        endcase
    end

    assign s_tready      = !core_rst && route_ready;
    assign accept        = s_tvalid && s_tready;
    assign slice_load[0] = accept && (sel == DEST_HS);
    assign slice_load[1] = accept && (sel == DEST_CTL);
    assign slice_load[2] = accept && (sel == DEST_DAT);

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dest_d = first_dest;
                    if (!s_tlast)
                        state_d = (first_dest == DEST_DROP) ? ST_DISCARD : ST_FWD;
                end
            end
            ST_FWD, ST_DISCARD: begin
                if (accept && s_tlast)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q   <= ST_IDLE;
            dest_q    <= DEST_DROP;
            rsp_pulse <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            rsp_pulse <= accept && first_beat && (first_dest != DEST_DROP);
            if (accept && first_beat && (first_dest == DEST_DROP) && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    axis_reg_slice #(.DATA_W(64), .KEEP_W(8)) u_hs_slice (
        .clk      (core_clk),
        .rst      (core_rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (slice_load[0]),
        .s_tready (slice_ready[0]),
        .s_tlast  (s_tlast),
        .m_tdata  (hs_tdata),
        .m_tkeep  (hs_tkeep),
        .m_tvalid (hs_tvalid),
        .m_tready (hs_tready),
        .m_tlast  (hs_tlast)
    );

    axis_reg_slice #(.DATA_W(64), .KEEP_W(8)) u_ctl_slice (
        .clk      (core_clk),
        .rst      (core_rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (slice_load[1]),
        .s_tready (slice_ready[1]),
        .s_tlast  (s_tlast),
        .m_tdata  (ctl_tdata),
        .m_tkeep  (ctl_tkeep),
        .m_tvalid (ctl_tvalid),
        .m_tready (ctl_tready),
        .m_tlast  (ctl_tlast)
    );

    axis_reg_slice #(.DATA_W(64), .KEEP_W(8)) u_dat_slice (
        .clk      (core_clk),
        .rst      (core_rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (slice_load[2]),
        .s_tready (slice_ready[2]),
        .s_tlast  (s_tlast),
        .m_tdata  (dat_tdata),
        .m_tkeep  (dat_tkeep),
        .m_tvalid (dat_tvalid),
        .m_tready (dat_tready),
        .m_tlast  (dat_tlast)
    );

endmodule

// File: tb/tb_udt_rx_demux.sv
// tb/tb_udt_rx_demux.sv - self-checking bench for udt_rx_demux
module tb_udt_rx_demux;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        conn_up;
    logic [63:0] hs_tdata, ctl_tdata, dat_tdata;
    logic [7:0]  hs_tkeep, ctl_tkeep, dat_tkeep;
    logic        hs_tvalid, ctl_tvalid, dat_tvalid;
    logic        hs_tlast, ctl_tlast, dat_tlast;
    logic        hs_tready, ctl_tready, dat_tready;
    logic        rsp_pulse;
    logic [15:0] drop_cnt;

    int nchecks = 0;
    int nerrors = 0;
    int exp_drop, exp_rsp, obs_rsp;
    bit bp_en, hs_hold;
    logic [72:0] q_hs[$];
    logic [72:0] q_ctl[$];
    logic [72:0] q_dat[$];

    always #5 core_clk = ~core_clk;

    udt_rx_demux #(.MAX_CTRL_TYPE(7), .DROP_CNT_W(16)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .s_tlast(s_tlast), .conn_up(conn_up),
        .hs_tdata(hs_tdata), .hs_tkeep(hs_tkeep), .hs_tvalid(hs_tvalid),
        .hs_tlast(hs_tlast), .hs_tready(hs_tready),
        .ctl_tdata(ctl_tdata), .ctl_tkeep(ctl_tkeep), .ctl_tvalid(ctl_tvalid),
        .ctl_tlast(ctl_tlast), .ctl_tready(ctl_tready),
        .dat_tdata(dat_tdata), .dat_tkeep(dat_tkeep), .dat_tvalid(dat_tvalid),
        .dat_tlast(dat_tlast), .dat_tready(dat_tready),
        .rsp_pulse(rsp_pulse), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: destination 0=hs 1=ctl 2=dat 3=dropped.
    function automatic int ref_dest(input logic [63:0] h, input int nbeats, input bit conn);
        int t = int'(h[62:48]);
        if (nbeats == 1) return 3;
        if (h[63] == 1'b0) return conn ? 2 : 3;
        if (t == 0) return 0;
        if ((t >= 1 && t <= 7) || t == 32767) return 1;
        return 3;
    endfunction

    function automatic logic port_valid(input int p);
        if (p == 0) return hs_tvalid;
        if (p == 1) return ctl_tvalid;
        return dat_tvalid;
    endfunction

    function automatic logic [63:0] port_data(input int p);
        if (p == 0) return hs_tdata;
        if (p == 1) return ctl_tdata;
        return dat_tdata;
    endfunction

    task automatic push_exp(input int p, input logic [72:0] b);
        if (p == 0) q_hs.push_back(b);
        else if (p == 1) q_ctl.push_back(b);
        else q_dat.push_back(b);
    endtask

    task automatic check_beat(input int p, input logic [72:0] obs);
        logic [72:0] e;
        int n;
        n = (p == 0) ? q_hs.size() : (p == 1) ? q_ctl.size() : q_dat.size();
        chk($sformatf("port%0d_beat_expected", p), 73'(n != 0), 73'd1);
        if (n != 0) begin
            if (p == 0) e = q_hs.pop_front();
            else if (p == 1) e = q_ctl.pop_front();
            else e = q_dat.pop_front();
            chk($sformatf("port%0d_beat", p), obs, e);
        end
    endtask

    always @(posedge core_clk) begin
        #1;
        hs_tready  = hs_hold ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
        ctl_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        dat_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge core_clk) begin
        if (core_rst) begin
            obs_rsp = 0;
        end else begin
            if (hs_tvalid && hs_tready)   check_beat(0, {hs_tlast, hs_tkeep, hs_tdata});
            if (ctl_tvalid && ctl_tready) check_beat(1, {ctl_tlast, ctl_tkeep, ctl_tdata});
            if (dat_tvalid && dat_tready) check_beat(2, {dat_tlast, dat_tkeep, dat_tdata});
            if (rsp_pulse) obs_rsp++;
        end
    end

    // Called between edges; returns one time unit after the accepting edge.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int waitc = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge core_clk);
        while (!s_tready && waitc < 200) begin
            @(negedge core_clk);
            waitc++;
        end
        chk("accept_timeout", 73'(waitc < 200), 73'd1);
        @(posedge core_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] hdr, input int nbeats, input bit conn);
        int d;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        d = ref_dest(hdr, nbeats, conn);
        conn_up = conn;
        for (int i = 0; i < nbeats; i++) begin
            last = (i == nbeats - 1);
            data = (i == 0) ? hdr : {$urandom, $urandom};
            if (last && i != 0) keep = 8'hFF << $urandom_range(0, 7);
            else if (i != 0 && $urandom_range(0, 5) == 0) keep = 8'h00;
            else keep = 8'hFF;
            if (d != 3) push_exp(d, {last, keep, data});
            drive_beat(data, keep, last);
            if (i == 0) begin
                chk("rsp_after_first_beat", 73'(rsp_pulse), 73'(d != 3));
                if (d != 3) begin
                    chk("first_beat_valid", 73'(port_valid(d)), 73'd1);
                    chk("first_beat_data", 73'(port_data(d)), 73'(hdr));
                end
                conn_up = 1'($urandom_range(0, 1));
            end
        end
        if (d == 3) begin
            if (exp_drop < 65535) exp_drop++;
        end else begin
            exp_rsp++;
        end
        chk("drop_cnt", 73'(drop_cnt), 73'(exp_drop));
    endtask

    task automatic drain();
        int w = 0;
        while ((q_hs.size() + q_ctl.size() + q_dat.size()) != 0 && w < 500) begin
            @(posedge core_clk);
            w++;
        end
        #1;
        chk("drain_timeout", 73'(w < 500), 73'd1);
        chk("egress_idle", 73'({hs_tvalid, ctl_tvalid, dat_tvalid}), 73'd0);
        chk("rsp_count", 73'(obs_rsp), 73'(exp_rsp));
        @(posedge core_clk);
        #1;
    endtask

    function automatic logic [63:0] rand_hdr();
        logic [14:0] t;
        case ($urandom_range(0, 4))
            0: t = 15'd0;
            1: t = ($urandom_range(0, 1) == 1) ? 15'h7FFF : 15'($urandom_range(1, 7));
            2: t = 15'($urandom_range(8, 32766));
            default: t = 15'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0)
            return {1'b0, 15'($urandom), 16'($urandom), 32'($urandom)};
        return {1'b1, t, 16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        core_rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        conn_up  = 1'b0;
        bp_en    = 1'b0;
        hs_hold  = 1'b0;
        exp_drop = 0;
        exp_rsp  = 0;
        repeat (3) @(posedge core_clk);
        #1;
        chk("reset_s_tready", 73'(s_tready), 73'd0);
        chk("reset_valids", 73'({hs_tvalid, ctl_tvalid, dat_tvalid}), 73'd0);
        chk("reset_drop_cnt", 73'(drop_cnt), 73'd0);
        chk("reset_rsp", 73'(rsp_pulse), 73'd0);
        core_rst = 1'b0;
        #1;
        chk("release_s_tready", 73'(s_tready), 73'd1);
        @(posedge core_clk);
        #1;

        send_pkt(64'h8000_0000_0000_0000, 6, 1'b1);
        drain();

        send_pkt(64'h0000_0010_0000_0000, 3, 1'b0);
        send_pkt(64'h0000_0010_0000_0000, 3, 1'b1);
        drain();

        send_pkt({1'b1, 15'd2, 48'h0000_0000_0001}, 3, 1'b1);
        send_pkt({1'b1, 15'h7FFF, 48'h0000_0000_0002}, 2, 1'b1);
        send_pkt({1'b1, 15'd9, 48'h0000_0000_0003}, 4, 1'b1);
        drain();

        send_pkt(64'h8000_0000_0000_0000, 1, 1'b1);
        @(negedge core_clk);
        chk("runt_s_tready", 73'(s_tready), 73'd1);
        @(posedge core_clk);
        #1;
        drain();

        hs_hold = 1'b1;
        repeat (2) begin
            @(posedge core_clk);
            #1;
        end
        fork
            begin
                send_pkt(64'h8000_0000_0000_0055, 2, 1'b1);
                send_pkt(64'h0000_0000_1234_5678, 3, 1'b1);
            end
            begin
                repeat (6) @(negedge core_clk);
                chk("stall_s_tready", 73'(s_tready), 73'd0);
                chk("stall_hs_held", 73'(hs_tvalid), 73'd1);
                chk("stall_dat_idle", 73'(dat_tvalid), 73'd0);
                hs_hold = 1'b0;
            end
        join
        drain();

        bp_en = 1'b1;
        for (int n = 0; n < 300; n++)
            send_pkt(rand_hdr(), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        bp_en = 1'b0;
        @(posedge core_clk);
        #1;
        drain();

        conn_up = 1'b1;
        q_hs.push_back({1'b0, 8'hFF, 64'h8000_0000_0000_0011});
        q_hs.push_back({1'b0, 8'hFF, 64'hDEAD_BEEF_0000_0002});
        drive_beat(64'h8000_0000_0000_0011, 8'hFF, 1'b0);
        drive_beat(64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b0);
        core_rst = 1'b1;
        #1;
        chk("midpkt_reset_valids", 73'({hs_tvalid, ctl_tvalid, dat_tvalid}), 73'd0);
        chk("midpkt_reset_drop_cnt", 73'(drop_cnt), 73'd0);
        chk("midpkt_reset_s_tready", 73'(s_tready), 73'd0);
        q_hs.delete();
        q_ctl.delete();
        q_dat.delete();
        exp_drop = 0;
        exp_rsp  = 0;
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        #1;
        chk("midpkt_release_s_tready", 73'(s_tready), 73'd1);
        @(posedge core_clk);
        #1;
        send_pkt(64'h8000_0000_0000_00AB, 2, 1'b1);
        drain();

        for (int n = 0; n < 65539; n++)
            send_pkt(rand_hdr(), 1, 1'b1);
        chk("drop_cnt_saturated", 73'(drop_cnt), 73'(16'hFFFF));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "global timeout");
    end

endmodule
